operand_loader: RTL and testbench

Host-side writer for the five 32-bit × 128-deep operand FIFOs (R2, N, M, phi_N, Ei) feeding the Montgomery exponentiation datapath. It accepts a single valid/ready word stream of framed operands, decodes each frame header, and steers the payload words onto the matching FIFO write port. It snoops the consumer's read enables to track per-FIFO occupancy, so it never overflows a FIFO. It also reports which operands have been completely loaded.

---
 rtl/operand_loader.sv | 137 +++++++++++++
 tb/tb_operand_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Steers a framed valid/ready word stream onto five operand FIFO write ports.
// Tracks per-FIFO occupancy from the consumer's read enables, so a FIFO is never overfilled.
module operand_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int OCC_W  = 8
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] din_0,
  output logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] din_2,
  output logic [DATA_W-1:0] din_3,
  output logic [DATA_W-1:0] din_4,
  output logic              wr_en_0,
  output logic              wr_en_1,
  output logic              wr_en_2,
  output logic              wr_en_3,
  output logic              wr_en_4,
  input  logic              rd_en_0,
  input  logic              rd_en_1,
  input  logic              rd_en_2,
  input  logic              rd_en_3,
  input  logic              rd_en_4,
  output logic [4:0]        loaded_mask,
  output logic              frame_done,
  output logic              err_sel,
  input  logic              clr,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a word moves on any cycle where s_valid & s_ready; s_ready never looks at s_valid.
  typedef enum logic [1:0] {HDR = 2'd0, LOAD = 2'd1, DROP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [2:0]        sel_q;
  logic [6:0]        rem_q;
  logic [DATA_W-1:0] din_q [5];
  logic [4:0]        wr_en_q;
  logic [OCC_W-1:0]  occ [5];
  logic [4:0]        rd_en_v, inc_v, dec_v, set_mask;
  logic [7:0]        full_v;
  logic [2:0]        hdr_sel;
  logic              accept, hdr_acc, load_acc, last_word;

  assign rd_en_v   = {rd_en_4, rd_en_3, rd_en_2, rd_en_1, rd_en_0};
  assign hdr_sel   = s_data[2:0];
  assign s_ready   = (state != LOAD) | ~full_v[sel_q];
  assign accept    = s_valid & s_ready;
  assign hdr_acc   = accept & (state == HDR);
  assign load_acc  = accept & (state == LOAD);
  assign last_word = (rem_q == 7'd0);

  always_comb begin
    full_v   = '0;
    inc_v    = '0;
    dec_v    = '0;
    set_mask = '0;
    for (int k = 0; k < 5; k++) begin
      full_v[k]   = (occ[k] == OCC_W'(DEPTH));
      inc_v[k]    = load_acc & (sel_q == 3'(k));
      dec_v[k]    = rd_en_v[k] & (occ[k] != '0);
      set_mask[k] = inc_v[k] & last_word;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     if (accept) state_nxt = (hdr_sel <= 3'd4) ? LOAD : DROP;
      LOAD:    if (accept && last_word) state_nxt = HDR;
      DROP:    if (accept && last_word) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) state <= HDR;
    else       state <= state_nxt;
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      sel_q       <= '0;
      rem_q       <= '0;
      wr_en_q     <= '0;
      frame_done  <= 1'b0;
      loaded_mask <= '0;
      err_sel     <= 1'b0;
      for (int k = 0; k < 5; k++) din_q[k] <= '0;
    end else begin
      wr_en_q    <= inc_v;
      frame_done <= load_acc & last_word;
      if (hdr_acc) begin
        sel_q <= hdr_sel;
        rem_q <= s_data[14:8];
      end else if (accept && !last_word) begin
        rem_q <= rem_q - 7'd1;
      end
      for (int k = 0; k < 5; k++)
        if (inc_v[k]) din_q[k] <= s_data;
      // A same-cycle clear wins over a set.
      loaded_mask <= clr ? 5'd0 : (loaded_mask | set_mask);
      err_sel     <= ~clr & (err_sel | (hdr_acc & (hdr_sel > 3'd4)));
    end
  end

  // Occupancy counts reserved slots: bumped on acceptance, before the write lands.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 5; k++) occ[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (inc_v[k] && !dec_v[k])      occ[k] <= occ[k] + 1'b1;
        else if (dec_v[k] && !inc_v[k]) occ[k] <= occ[k] - 1'b1;
      end
    end
  end

  assign din_0     = din_q[0];
  assign din_1     = din_q[1];
  assign din_2     = din_q[2];
  assign din_3     = din_q[3];
  assign din_4     = din_q[4];
  assign wr_en_0   = wr_en_q[0];
  assign wr_en_1   = wr_en_q[1];
  assign wr_en_2   = wr_en_q[2];
  assign wr_en_3   = wr_en_q[3];
  assign wr_en_4   = wr_en_q[4];
  assign busy      = (state != HDR);
  assign dbg_state = state;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios then a random frame sweep, checked against
// a frame-level model with per-FIFO expected-write queues.
module tb_operand_loader;
  localparam int DEPTH = 128;

  logic        clka = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] din_0, din_1, din_2, din_3, din_4;
  logic        wr_en_0, wr_en_1, wr_en_2, wr_en_3, wr_en_4;
  logic [4:0]  rd_en = '0;
  logic [4:0]  loaded_mask;
  logic        frame_done, err_sel, busy;
  logic        clr = 1'b0;
  logic [1:0]  dbg_state;

  operand_loader dut (
    .clka(clka), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3), .din_4(din_4),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2), .wr_en_3(wr_en_3), .wr_en_4(wr_en_4),
    .rd_en_0(rd_en[0]), .rd_en_1(rd_en[1]), .rd_en_2(rd_en[2]), .rd_en_3(rd_en[3]), .rd_en_4(rd_en[4]),
    .loaded_mask(loaded_mask), .frame_done(frame_done), .err_sel(err_sel),
    .clr(clr), .busy(busy), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clka = ~clka;

  logic [31:0] din_a [5];
  logic [4:0]  wr_v;
  logic [7:0]  dut_occ [5];
  assign din_a[0] = din_0;
  assign din_a[1] = din_1;
  assign din_a[2] = din_2;
  assign din_a[3] = din_3;
  assign din_a[4] = din_4;
  assign wr_v = {wr_en_4, wr_en_3, wr_en_2, wr_en_1, wr_en_0};
  assign dut_occ[0] = dut.occ[0];
  assign dut_occ[1] = dut.occ[1];
  assign dut_occ[2] = dut.occ[2];
  assign dut_occ[3] = dut.occ[3];
  assign dut_occ[4] = dut.occ[4];

  int vectors = 0;
  int miscompares = 0;
  bit rnd_mode = 0;

  // Frame-level reference model
  bit          m_busy, m_drop;
  int          m_tgt, m_left;
  int          m_occ [5];
  logic [31:0] m_din [5];
  logic [4:0]  m_mask;
  bit          m_err;
  logic [31:0] exp_q [5][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_tgt = 0; m_left = 0; m_mask = '0; m_err = 0;
    for (int k = 0; k < 5; k++) begin
      m_occ[k] = 0;
      m_din[k] = '0;
      exp_q[k].delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_wr_en", wr_v, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst_din_%0d", k), din_a[k], 0);
      chk($sformatf("rst_occ_%0d", k), dut_occ[k], 0);
    end
    chk("rst_loaded_mask", loaded_mask, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_sel", err_sel, 0);
    chk("rst_busy", busy, 0);
  endtask

  // One clock: predict from current inputs, clock, then check every output.
  task automatic cycle(output bit acc);
    bit         rdy, exp_fd;
    logic [4:0] exp_wr, set_m;
    bit         set_e;
    int         inc [5];
    if (rnd_mode)
      for (int k = 0; k < 5; k++) rd_en[k] = ($urandom_range(0, 2) == 0);
    #1;
    rdy = !m_busy || m_drop || (m_occ[m_tgt] < DEPTH);
    chk("s_ready", s_ready, rdy);
    acc = s_valid && rdy;
    exp_wr = '0; exp_fd = 0; set_m = '0; set_e = 0;
    for (int k = 0; k < 5; k++) inc[k] = 0;
    if (acc) begin
      if (!m_busy) begin
        m_tgt  = int'(s_data[2:0]);
        m_left = int'(s_data[14:8]) + 1;
        m_busy = 1;
        m_drop = (m_tgt > 4);
        set_e  = m_drop;
      end else begin
        if (!m_drop) begin
          exp_wr[m_tgt] = 1'b1;
          exp_q[m_tgt].push_back(s_data);
          m_din[m_tgt] = s_data;
          inc[m_tgt] = 1;
        end
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          if (!m_drop) begin
            exp_fd = 1;
            set_m[m_tgt] = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < 5; k++)
      m_occ[k] = m_occ[k] + inc[k] - ((rd_en[k] && m_occ[k] > 0) ? 1 : 0);
    m_mask = clr ? 5'd0 : (m_mask | set_m);
    m_err  = clr ? 1'b0 : (m_err | set_e);
    @(posedge clka);
    #1;
    chk("wr_en", wr_v, exp_wr);
    for (int k = 0; k < 5; k++) begin
      if (wr_v[k] && exp_q[k].size() > 0)
        chk($sformatf("wr_data_%0d", k), din_a[k], exp_q[k].pop_front());
      chk($sformatf("din_hold_%0d", k), din_a[k], m_din[k]);
      chk($sformatf("occ_%0d", k), dut_occ[k], m_occ[k]);
    end
    chk("frame_done", frame_done, exp_fd);
    chk("loaded_mask", loaded_mask, m_mask);
    chk("err_sel", err_sel, m_err);
    chk("busy", busy, m_busy);
  endtask

  // driver task: offer one word until accepted, with a bounded wait
  task automatic send(input logic [31:0] w);
    bit acc;
    int n;
    if (rnd_mode)
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        cycle(acc);
      end
    s_valid = 1'b1;
    s_data  = w;
    acc = 0;
    n = 0;
    while (!acc && n < 400) begin
      cycle(acc);
      n++;
    end
    chk("send_accept", acc, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clka);
    #1;
    rstn = 1'b1;

    // Load N: four words
    send(32'h0000_0301);
    for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i));
    s_valid = 1'b0;
    cycle(acc);
    chk("loadN_mask", loaded_mask, 5'b00010);
    chk("loadN_occ1", dut_occ[1], 4);

    // Overflow guard: fill R2, then one more word must wait for a read
    send(32'h0000_7F00);
    for (int i = 0; i < 128; i++) send(32'h1000 + 32'(i));
    send(32'h0000_0000);
    s_valid = 1'b1;
    s_data  = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("ovf_stall", acc, 0);
    end
    rd_en = 5'b00001;
    cycle(acc);
    chk("ovf_stall_rd", acc, 0);
    rd_en = 5'b00000;
    cycle(acc);
    chk("ovf_accept", acc, 1);
    s_valid = 1'b0;
    chk("ovf_occ0", dut_occ[0], DEPTH);

    // Bad select: sel=6, three words dropped
    send(32'h0000_0206);
    for (int i = 0; i < 3; i++) send(32'hDD00 + 32'(i));
    s_valid = 1'b0;
    cycle(acc);
    chk("badsel_err", err_sel, 1);
    chk("badsel_mask", loaded_mask, 5'b00011);

    // Ei frame with clr on the last word; rd_en on empty M
    send(32'h0000_0104);
    send(32'hE0);
    clr = 1'b1;
    rd_en = 5'b00100;
    send(32'hE1);
    clr = 1'b0;
    rd_en = 5'b00000;
    s_valid = 1'b0;
    cycle(acc);
    chk("clr_mask4", loaded_mask[4], 0);
    chk("clr_err", err_sel, 0);
    chk("empty_rd_occ2", dut_occ[2], 0);

    // Reset mid-frame after 2 of 5 M words
    send(32'h0000_0402);
    send(32'hC0);
    send(32'hC1);
    rstn = 1'b0;
    s_valid = 1'b0;
    #2;
    model_reset();
    check_reset_outputs();
    @(posedge clka);
    #1;
    rstn = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h0000_0002;
    cycle(acc);
    chk("hdr_after_rst", acc, 1);
    send(32'hD0);
    s_valid = 1'b0;
    cycle(acc);

    // Random sweep
    rnd_mode = 1;
    for (int f = 0; f < 50; f++) begin
      int sel, len;
      sel = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 15);
      send(($urandom() & 32'hFFFF_80F8) | (32'(len) << 8) | 32'(sel));
      for (int i = 0; i <= len; i++) send($urandom());
    end
    rnd_mode = 0;
    s_valid = 1'b0;
    rd_en = 5'b00000;
    for (int i = 0; i < 4; i++) cycle(acc);
    for (int k = 0; k < 5; k++) chk($sformatf("q_empty_%0d", k), exp_q[k].size(), 0);

    $display("final debug state %0d", dbg_state);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
